// File: rtl/bram_arbiter.sv
// Two-client arbiter for a simple-dual-port BRAM. The write and read ports are arbitrated independently.
// Define BRAM_ARB_ROUND_ROBIN_EN for round-robin contention; otherwise client 0 has fixed priority.
module bram_arbiter #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [WIDTH-1:0]  wdata0,
  input  logic [WIDTH-1:0]  wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [WIDTH-1:0]  rdata,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_wr_add,
  output logic [WIDTH-1:0]  bram_wr_data,
  output logic              bram_rd_en,
  output logic [ADDR_W-1:0] bram_rd_add,
  input  logic [WIDTH-1:0]  bram_rd_data
);

  if ((1 << ADDR_W) < DEPTH) begin : g_bad_addr_w
    $error("ADDR_W too narrow for DEPTH");
  end

  logic wr_c0_s, wr_c1_s, rd_c0_s, rd_c1_s;
  logic wr_cont_s, rd_cont_s;
  logic wr_gnt_s, rd_gnt_s;
  logic wr_sel1_s, rd_sel1_s;
  logic wr_prio_s, rd_prio_s;
  logic rd_pend_r, rd_owner_r;

  assign wr_c0_s   = req0 & we0;
  assign wr_c1_s   = req1 & we1;
  assign rd_c0_s   = req0 & ~we0;
  assign rd_c1_s   = req1 & ~we1;
  assign wr_cont_s = wr_c0_s & wr_c1_s;
  assign rd_cont_s = rd_c0_s & rd_c1_s;

`ifdef BRAM_ARB_ROUND_ROBIN_EN
  logic wptr_r, rptr_r;
  assign wr_prio_s = wptr_r;
  assign rd_prio_s = rptr_r;

  // Priority pointers move to the loser after every contended grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_r <= 1'b0;
      rptr_r <= 1'b0;
    end else begin
      if (wr_cont_s) begin
        wptr_r <= ~wr_sel1_s;
      end else begin
        wptr_r <= wptr_r;
      end
      if (rd_cont_s) begin
        rptr_r <= ~rd_sel1_s;
      end else begin
        rptr_r <= rptr_r;
      end
    end
  end
`else
  assign wr_prio_s = 1'b0;
  assign rd_prio_s = 1'b0;
`endif

  // Per-port winner selection; sel1 means client 1 owns that port this cycle.
  always_comb begin
    wr_gnt_s  = 1'b0;
    rd_gnt_s  = 1'b0;
    wr_sel1_s = 1'b0;
    rd_sel1_s = 1'b0;
    if (rst) begin
      wr_gnt_s = 1'b0;
      rd_gnt_s = 1'b0;
    end else begin
      wr_gnt_s = wr_c0_s | wr_c1_s;
      rd_gnt_s = rd_c0_s | rd_c1_s;
      if (wr_cont_s) begin
        wr_sel1_s = wr_prio_s;
      end else begin
        wr_sel1_s = wr_c1_s;
      end
      if (rd_cont_s) begin
        rd_sel1_s = rd_prio_s;
      end else begin
        rd_sel1_s = rd_c1_s;
      end
    end
  end

  assign gnt0 = (wr_gnt_s & ~wr_sel1_s) | (rd_gnt_s & ~rd_sel1_s);
  assign gnt1 = (wr_gnt_s &  wr_sel1_s) | (rd_gnt_s &  rd_sel1_s);

  assign bram_we      = wr_gnt_s;
  assign bram_wr_add  = wr_sel1_s ? addr1 : addr0;
  assign bram_wr_data = wr_sel1_s ? wdata1 : wdata0;
  assign bram_rd_en   = rd_gnt_s;
  assign bram_rd_add  = rd_sel1_s ? addr1 : addr0;
  assign rdata        = bram_rd_data;

  // Track the owner of the read in flight so its data is steered back next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pend_r  <= 1'b0;
      rd_owner_r <= 1'b0;
    end else begin
      rd_pend_r  <= rd_gnt_s;
      rd_owner_r <= rd_sel1_s;
    end
  end

  // A reset in the cycle after a read grant drops that read.
  assign rvalid0 = rd_pend_r & ~rd_owner_r & ~rst;
  assign rvalid1 = rd_pend_r &  rd_owner_r & ~rst;

endmodule

// File: tb/tb_bram_arbiter.sv
// Self-checking bench for bram_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_bram_arbiter;
  localparam int WIDTH = 32;
  localparam int DEPTH = 8;
  localparam int ADDR_W = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [ADDR_W-1:0] addr0 = '0, addr1 = '0;
  logic [WIDTH-1:0] wdata0 = '0, wdata1 = '0;
  logic gnt0, gnt1, rvalid0, rvalid1, bram_we, bram_rd_en;
  logic [WIDTH-1:0] rdata, bram_wr_data;
  logic [WIDTH-1:0] bram_rd_data;
  logic [ADDR_W-1:0] bram_wr_add, bram_rd_add;

  int n_cmp = 0;
  int n_bad = 0;

  bram_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata),
    .bram_we(bram_we), .bram_wr_add(bram_wr_add), .bram_wr_data(bram_wr_data),
    .bram_rd_en(bram_rd_en), .bram_rd_add(bram_rd_add), .bram_rd_data(bram_rd_data)
  );

  always #5 clk = ~clk;

  // BRAM: registered read-first read port, one write port.
  logic [WIDTH-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (bram_rd_en) bram_rd_data <= mem[bram_rd_add];
    if (bram_we) mem[bram_wr_add] <= bram_wr_data;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Behavioural model: contenders per port, pointer to loser on contention, one-cycle read return.
  logic [WIDTH-1:0] ref_mem [DEPTH];
  int m_wptr = 0, m_rptr = 0, m_owner = 0, m_ww, m_rw;
  bit m_pend = 0, ev0, ev1;
  logic [WIDTH-1:0] m_rdata;

  function automatic int pick(bit c0, bit c1, int ptr);
    if (c0 && c1) return ptr;
    if (c0) return 0;
    if (c1) return 1;
    return -1;
  endfunction

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = 32'h1000 + i;
      ref_mem[i] = 32'h1000 + i;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      m_ww = -1;
      m_rw = -1;
    end else begin
      m_ww = pick(req0 && we0, req1 && we1, m_wptr);
      m_rw = pick(req0 && !we0, req1 && !we1, m_rptr);
    end
    chk("m_gnt0", gnt0, 64'(m_ww == 0 || m_rw == 0));
    chk("m_gnt1", gnt1, 64'(m_ww == 1 || m_rw == 1));
    chk("m_bram_we", bram_we, 64'(m_ww >= 0));
    chk("m_bram_rd_en", bram_rd_en, 64'(m_rw >= 0));
    if (m_ww >= 0) begin
      chk("m_wr_add", bram_wr_add, (m_ww == 0) ? addr0 : addr1);
      chk("m_wr_data", bram_wr_data, (m_ww == 0) ? wdata0 : wdata1);
    end
    if (m_rw >= 0) chk("m_rd_add", bram_rd_add, (m_rw == 0) ? addr0 : addr1);
    ev0 = !rst && m_pend && m_owner == 0;
    ev1 = !rst && m_pend && m_owner == 1;
    chk("m_rvalid0", rvalid0, 64'(ev0));
    chk("m_rvalid1", rvalid1, 64'(ev1));
    if (ev0 || ev1) chk("m_rdata", rdata, m_rdata);
    // Advance model state to what the coming edge produces.
    if (rst) begin
      m_pend = 0;
      m_wptr = 0;
      m_rptr = 0;
    end else begin
      m_pend = (m_rw >= 0);
      m_owner = m_rw;
      if (m_rw >= 0) m_rdata = ref_mem[(m_rw == 0) ? addr0 : addr1];
      if (m_ww >= 0) ref_mem[(m_ww == 0) ? addr0 : addr1] = (m_ww == 0) ? wdata0 : wdata1;
`ifdef BRAM_ARB_ROUND_ROBIN_EN
      if (req0 && req1 && we0 && we1) m_wptr = 1 - m_ww;
      if (req0 && req1 && !we0 && !we1) m_rptr = 1 - m_rw;
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setc(input bit r0, input bit w0, input int a0, input logic [WIDTH-1:0] d0,
                      input bit r1, input bit w1, input int a1, input logic [WIDTH-1:0] d1);
    req0 = r0; we0 = w0; addr0 = 3'(a0); wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = 3'(a1); wdata1 = d1;
  endtask

  bit rr;
  bit h0, h1;
  bit exp_g0, exp_g1, prev_g0, prev_g1;

  initial begin
`ifdef BRAM_ARB_ROUND_ROBIN_EN
    rr = 1'b1;
`else
    rr = 1'b0;
`endif
    // Reset holds grants and enables low even with requests pending.
    step();
    setc(1'b1, 1'b1, 1, 32'h5, 1'b1, 1'b0, 2, 32'h0);
    #1;
    chk("rst_gnt0", gnt0, 64'd0);
    chk("rst_gnt1", gnt1, 64'd0);
    chk("rst_we", bram_we, 64'd0);
    chk("rst_rd_en", bram_rd_en, 64'd0);
    step();
    chk("rst_rvalid0", rvalid0, 64'd0);
    chk("rst_rvalid1", rvalid1, 64'd0);
    rst = 1'b0;
    setc(1'b0, 1'b0, 0, 32'h0, 1'b0, 1'b0, 0, 32'h0);

    // Write then read back through the other client.
    step(); setc(1'b1, 1'b1, 3, 32'hDEADBEEF, 1'b0, 1'b0, 0, 32'h0); #1;
    chk("t1_wr_gnt0", gnt0, 64'd1);
    step(); setc(1'b0, 1'b0, 0, 32'h0, 1'b1, 1'b0, 3, 32'h0); #1;
    chk("t1_rd_gnt1", gnt1, 64'd1);
    step(); setc(1'b0, 1'b0, 0, 32'h0, 1'b0, 1'b0, 0, 32'h0); #1;
    chk("t1_rvalid1", rvalid1, 64'd1);
    chk("t1_rvalid0", rvalid0, 64'd0);
    chk("t1_rdata", rdata, 64'hDEADBEEF);

    // Concurrent write (client 0) and read (client 1).
    step(); setc(1'b1, 1'b1, 2, 32'h11, 1'b1, 1'b0, 5, 32'h0); #1;
    chk("t2_gnt0", gnt0, 64'd1);
    chk("t2_gnt1", gnt1, 64'd1);
    step(); setc(1'b1, 1'b0, 2, 32'h0, 1'b0, 1'b0, 0, 32'h0); #1;
    chk("t2_rvalid1", rvalid1, 64'd1);
    chk("t2_rdata_old5", rdata, 64'h1005);
    step(); setc(1'b0, 1'b0, 0, 32'h0, 1'b0, 1'b0, 0, 32'h0); #1;
    chk("t2_rvalid0", rvalid0, 64'd1);
    chk("t2_rdata_new2", rdata, 64'h11);

    // Continuous contended reads for 6 cycles.
    prev_g0 = 1'b0; prev_g1 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(); setc(1'b1, 1'b0, 1, 32'h0, 1'b1, 1'b0, 2, 32'h0); #1;
      exp_g0 = rr ? (i % 2 == 0) : 1'b1;
      exp_g1 = rr ? (i % 2 == 1) : 1'b0;
      chk("t3_gnt0", gnt0, 64'(exp_g0));
      chk("t3_gnt1", gnt1, 64'(exp_g1));
      chk("t3_rvalid0", rvalid0, 64'(prev_g0));
      chk("t3_rvalid1", rvalid1, 64'(prev_g1));
      prev_g0 = exp_g0; prev_g1 = exp_g1;
    end
    step(); setc(1'b0, 1'b0, 0, 32'h0, 1'b0, 1'b0, 0, 32'h0); #1;
    chk("t3_last_rvalid1", rvalid1, 64'(prev_g1));

    // Same-address read and write in one cycle returns old data.
    step(); setc(1'b1, 1'b1, 4, 32'hAA, 1'b0, 1'b0, 0, 32'h0);
    step(); setc(1'b1, 1'b1, 4, 32'hBB, 1'b1, 1'b0, 4, 32'h0); #1;
    chk("t4_gnt0", gnt0, 64'd1);
    chk("t4_gnt1", gnt1, 64'd1);
    step(); setc(1'b0, 1'b0, 0, 32'h0, 1'b1, 1'b0, 4, 32'h0); #1;
    chk("t4_rdata_old", rdata, 64'hAA);
    step(); setc(1'b0, 1'b0, 0, 32'h0, 1'b0, 1'b0, 0, 32'h0); #1;
    chk("t4_rdata_new", rdata, 64'hBB);

    // Reset in the cycle after a read grant drops the read and clears pointers.
    step(); setc(1'b1, 1'b0, 1, 32'h0, 1'b1, 1'b0, 2, 32'h0); #1;
    chk("t5_gnt0", gnt0, 64'd1);
    step(); rst = 1'b1; setc(1'b0, 1'b0, 0, 32'h0, 1'b0, 1'b0, 0, 32'h0); #1;
    chk("t5_rvalid0_n1", rvalid0, 64'd0);
    step(); rst = 1'b0; setc(1'b1, 1'b0, 1, 32'h0, 1'b1, 1'b0, 2, 32'h0); #1;
    chk("t5_rvalid0_n2", rvalid0, 64'd0);
    chk("t5_post_gnt0", gnt0, 64'd1);
    chk("t5_post_gnt1", gnt1, 64'd0);
    step(); setc(1'b0, 1'b0, 0, 32'h0, 1'b0, 1'b0, 0, 32'h0);

    // Randomized traffic; a client holds its request until granted.
    for (int c = 0; c < 3000; c++) begin
      h0 = req0 && !gnt0;
      h1 = req1 && !gnt1;
      step();
      rst = ($urandom_range(0, 199) == 0);
      if (!h0) begin
        req0 = ($urandom_range(0, 3) != 0);
        we0 = 1'($urandom_range(0, 1));
        addr0 = 3'($urandom_range(0, 7));
        wdata0 = $urandom;
      end
      if (!h1) begin
        req1 = ($urandom_range(0, 3) != 0);
        we1 = 1'($urandom_range(0, 1));
        addr1 = 3'($urandom_range(0, 7));
        wdata1 = $urandom;
      end
    end
    step(); rst = 1'b0; setc(1'b0, 1'b0, 0, 32'h0, 1'b0, 1'b0, 0, 32'h0);
    step(); step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
